// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the convolver column sequencer and its neighbours
// (micro_sim, Conv, bram_memory): default datapath geometry, the sequencer
// state encoding and a helper that sizes the kernel-column index.
package conv_pkg;

    localparam int DEF_NB_ADDRESS = 10;  // BRAM address width
    localparam int DEF_M_LEN      = 3;   // kernel columns
    localparam int DEF_RD_LAT     = 1;   // BRAM address-to-data latency
    localparam int DEF_WR_LAG     = 4;   // read issue to convolver result

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_KLOAD = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    // A single kernel column still needs a one-bit index port.
    function automatic int kcol_width(input int m_len);
        return (m_len > 1) ? $clog2(m_len) : 1;
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if
// Handshake and datapath-control bundle between the micro's GPIO register
// (master) and the column sequencer (slave).
//   i_start, i_hold, i_img_len : micro -> sequencer
//   o_conv_rst, o_k_i, o_valid, o_kcol : sequencer -> convolver
//   o_rd_addr, o_wr_addr, o_wr_en      : sequencer -> BRAMs
//   o_busy, o_done                     : sequencer -> micro status
interface conv_sequencer_if #(
    parameter int NB_ADDRESS = conv_pkg::DEF_NB_ADDRESS,
    parameter int KCOL_W     = conv_pkg::kcol_width(conv_pkg::DEF_M_LEN)
);
    logic                  i_start;
    logic                  i_hold;
    logic [NB_ADDRESS-1:0] i_img_len;
    logic                  o_conv_rst;
    logic                  o_k_i;
    logic                  o_valid;
    logic [KCOL_W-1:0]     o_kcol;
    logic [NB_ADDRESS-1:0] o_rd_addr;
    logic [NB_ADDRESS-1:0] o_wr_addr;
    logic                  o_wr_en;
    logic                  o_busy;
    logic                  o_done;

    modport master (
        output i_start, i_hold, i_img_len,
        input  o_conv_rst, o_k_i, o_valid, o_kcol,
        input  o_rd_addr, o_wr_addr, o_wr_en, o_busy, o_done
    );

    modport slave (
        input  i_start, i_hold, i_img_len,
        output o_conv_rst, o_k_i, o_valid, o_kcol,
        output o_rd_addr, o_wr_addr, o_wr_en, o_busy, o_done
    );
endinterface

// File: rtl/seq_delay_line.sv
// seq_delay_line
// Bit-wide shift register carrying the read-issue flag down the pipeline.
//   CLK100MHZ : clock
//   rst       : synchronous active-high clear of every stage
//   din       : flag entering the line this cycle
//   taps      : taps[k] is din delayed by k+1 cycles
module seq_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic             CLK100MHZ,
    input  logic             rst,
    input  logic             din,
    output logic [DEPTH-1:0] taps
);
    logic [DEPTH-1:0] line_reg;
    logic [DEPTH-1:0] line_next;

    assign line_next[0] = din;
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            assign line_next[gi] = line_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            line_reg <= '0;
        end else begin
            line_reg <= line_next;
        end
    end

    assign taps = line_reg;
endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer
// Autonomous controller for the convolver + three-BRAM column datapath:
// clears the convolver, optionally loads the kernel columns, streams image
// columns out of the BRAMs and writes results back WR_LAG cycles later.
//   CLK100MHZ : clock
//   i_reset   : synchronous active-high reset
//   bus       : conv_sequencer_if slave (start/hold/length in, convolver
//               and BRAM controls plus busy/done out); all outputs registered
// Build option: CONV_SEQ_KLOAD_EN defined adds the kernel-load phase (with
// a convolver reset in CLEAR); undefined, the kernel is taken as resident
// and CLEAR goes straight to RUN.
// WR_LAG must be at least RD_LAT+1.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int NB_ADDRESS = DEF_NB_ADDRESS,
    parameter int M_LEN      = DEF_M_LEN,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int WR_LAG     = DEF_WR_LAG,
    parameter int KCOL_W     = kcol_width(M_LEN)
) (
    input  logic           CLK100MHZ,
    input  logic           i_reset,
    conv_sequencer_if.slave bus
);
    seq_state_t            state_reg, state_next;
    logic [NB_ADDRESS-1:0] len_q_reg, len_q_next;
    logic [NB_ADDRESS-1:0] rd_addr_reg, rd_addr_next;
    logic [NB_ADDRESS-1:0] wr_addr_reg, wr_addr_next;
    logic                  conv_rst_reg, k_i_reg, valid_reg, busy_reg, done_reg;
    logic                  issue;
    logic                  valid_pre;
    logic                  line_drained;
    logic [WR_LAG-1:0]     taps;

    seq_delay_line #(.DEPTH(WR_LAG)) u_delay (
        .CLK100MHZ (CLK100MHZ),
        .rst       (i_reset),
        .din       (issue),
        .taps      (taps)
    );

    // o_valid is registered, so it is fed from one stage before RD_LAT.
    generate
        if (RD_LAT == 1) begin : g_valid_direct
            assign valid_pre = issue;
        end else begin : g_valid_tap
            assign valid_pre = taps[RD_LAT-2];
        end
    endgenerate

    // Only DRAIN consults this; with no new issue, the line is empty next
    // cycle once every stage before the write tap is clear.
    assign line_drained = ~|taps[WR_LAG-2:0];

`ifdef CONV_SEQ_KLOAD_EN
    logic [KCOL_W-1:0] kcnt_reg, kcnt_next;
`endif

    always_comb begin
        state_next   = state_reg;
        len_q_next   = len_q_reg;
        rd_addr_next = rd_addr_reg;
        wr_addr_next = wr_addr_reg;
        issue        = 1'b0;
`ifdef CONV_SEQ_KLOAD_EN
        kcnt_next    = '0;
`endif
        if (taps[WR_LAG-1]) begin
            wr_addr_next = wr_addr_reg + NB_ADDRESS'(1);
        end
        case (state_reg)
            ST_IDLE: begin
                if (bus.i_start) begin
                    len_q_next = bus.i_img_len;
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                rd_addr_next = '0;
                wr_addr_next = '0;
`ifdef CONV_SEQ_KLOAD_EN
                state_next   = ST_KLOAD;
`else
                state_next   = (len_q_reg == '0) ? ST_DONE : ST_RUN;
`endif
            end
`ifdef CONV_SEQ_KLOAD_EN
            ST_KLOAD: begin
                if (kcnt_reg == KCOL_W'(M_LEN - 1)) begin
                    state_next = (len_q_reg == '0) ? ST_DONE : ST_RUN;
                end else begin
                    kcnt_next = kcnt_reg + KCOL_W'(1);
                end
            end
`endif
            ST_RUN: begin
                if (!bus.i_hold) begin
                    issue        = 1'b1;
                    rd_addr_next = rd_addr_reg + NB_ADDRESS'(1);
                    if (rd_addr_reg == len_q_reg - NB_ADDRESS'(1)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (line_drained) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.i_start) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe.
    always_ff @(posedge CLK100MHZ) begin
        if (i_reset) begin
            state_reg    <= ST_IDLE;
            len_q_reg    <= '0;
            rd_addr_reg  <= '0;
            wr_addr_reg  <= '0;
            conv_rst_reg <= 1'b0;
            k_i_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_q_reg    <= len_q_next;
            rd_addr_reg  <= rd_addr_next;
            wr_addr_reg  <= wr_addr_next;
`ifdef CONV_SEQ_KLOAD_EN
            conv_rst_reg <= (state_next == ST_CLEAR);
            k_i_reg      <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
            valid_reg    <= (state_next == ST_KLOAD) || valid_pre;
`else
            conv_rst_reg <= 1'b0;
            k_i_reg      <= (state_next != ST_IDLE);
            valid_reg    <= valid_pre;
`endif
            busy_reg     <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            done_reg     <= (state_next == ST_DONE);
        end
    end

`ifdef CONV_SEQ_KLOAD_EN
    always_ff @(posedge CLK100MHZ) begin
        if (i_reset) begin
            kcnt_reg <= '0;
        end else begin
            kcnt_reg <= kcnt_next;
        end
    end
    assign bus.o_kcol = kcnt_reg;
`else
    assign bus.o_kcol = '0;
`endif

    assign bus.o_conv_rst = conv_rst_reg;
    assign bus.o_k_i      = k_i_reg;
    assign bus.o_valid    = valid_reg;
    assign bus.o_rd_addr  = rd_addr_reg;
    assign bus.o_wr_addr  = wr_addr_reg;
    assign bus.o_wr_en    = taps[WR_LAG-1];
    assign bus.o_busy     = busy_reg;
    assign bus.o_done     = done_reg;
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer
// Frame-level bench for conv_sequencer. Each frame gets a per-cycle start /
// hold / length schedule; a reference built from the timing rules (issue
// list in time, writes WR_LAG later, done after the last write) gives the
// expected value of every output in every cycle.
module tb_conv_sequencer;
    import conv_pkg::*;

    localparam int NA   = DEF_NB_ADDRESS;
    localparam int ML   = DEF_M_LEN;
    localparam int RL   = DEF_RD_LAT;
    localparam int WL   = DEF_WR_LAG;
    localparam int KW   = kcol_width(ML);
`ifdef CONV_SEQ_KLOAD_EN
    localparam int KL   = ML;
`else
    localparam int KL   = 0;
`endif
    localparam int MAXC = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_sequencer_if #(.NB_ADDRESS(NA), .KCOL_W(KW)) bus ();

    conv_sequencer dut (
        .CLK100MHZ (clk),
        .i_reset   (rst),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    bit hold_s  [MAXC];
    bit start_s [MAXC];
    int issue_idx [MAXC];
    int len_alt;

    task automatic prep(input int len);
        for (int i = 0; i < MAXC; i++) begin
            hold_s[i]  = 1'b0;
            start_s[i] = 1'b0;
        end
        start_s[0] = 1'b1;
        len_alt = len;
    endtask

    // Runs one frame from IDLE (cycle 0 = start sampled) back to IDLE.
    task automatic run_frame(input int len, input string name);
        int run_start, n, c, last, done_c, exit_c, issued, writes, first_done;
        logic [KW-1:0] exp_kcol;
        bit exp_valid, exp_wr, in_kload, in_run;
        int rd_i, wr_i;
        run_start = 2 + KL;
        for (int i = 0; i < MAXC; i++) issue_idx[i] = -1;
        n = 0; c = run_start; last = -1;
        while (n < len && c < MAXC - 40) begin
            if (!hold_s[c]) begin
                issue_idx[c] = n;
                n++;
                last = c;
            end
            c++;
        end
        done_c = (len == 0) ? run_start : last + WL + 1;
        exit_c = done_c;
        while (start_s[exit_c]) exit_c++;
        issued = 0; writes = 0; first_done = -1;
        for (int i = 0; i <= exit_c + 2; i++) begin
            bus.i_start   = start_s[i];
            bus.i_hold    = hold_s[i];
            bus.i_img_len = (i == 0) ? NA'(len) : NA'(len_alt);
            @(negedge clk);
            in_kload  = (i >= 2) && (i < 2 + KL);
            in_run    = (len > 0) && (i >= run_start) && (i <= last);
            exp_kcol  = in_kload ? KW'(i - 2) : '0;
            rd_i      = (i >= RL) ? issue_idx[i-RL] : -1;
            wr_i      = (i >= WL) ? issue_idx[i-WL] : -1;
            exp_valid = in_kload || (rd_i >= 0);
            exp_wr    = (wr_i >= 0);
            checks += 6;
            if (bus.o_conv_rst !== ((KL > 0) && (i == 1))) begin
                errors++;
                $display("FAIL %s conv_rst cyc %0d: got %b", name, i, bus.o_conv_rst);
            end
            if (bus.o_kcol !== exp_kcol) begin
                errors++;
                $display("FAIL %s kcol cyc %0d: got %0d want %0d", name, i, bus.o_kcol, exp_kcol);
            end
            if (bus.o_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s valid cyc %0d: got %b want %b", name, i, bus.o_valid, exp_valid);
            end
            if (bus.o_wr_en !== exp_wr) begin
                errors++;
                $display("FAIL %s wr_en cyc %0d: got %b want %b", name, i, bus.o_wr_en, exp_wr);
            end
            if (bus.o_busy !== ((i >= 1) && (i < done_c))) begin
                errors++;
                $display("FAIL %s busy cyc %0d: got %b", name, i, bus.o_busy);
            end
            if (bus.o_done !== ((i >= done_c) && (i <= exit_c))) begin
                errors++;
                $display("FAIL %s done cyc %0d: got %b", name, i, bus.o_done);
            end
            if (exp_wr) begin
                checks++;
                if (bus.o_wr_addr !== NA'(wr_i)) begin
                    errors++;
                    $display("FAIL %s wr_addr cyc %0d: got %0d want %0d", name, i, bus.o_wr_addr, wr_i);
                end
            end
            if (in_run) begin
                checks += 2;
                if (bus.o_rd_addr !== NA'(issued)) begin
                    errors++;
                    $display("FAIL %s rd_addr cyc %0d: got %0d want %0d", name, i, bus.o_rd_addr, issued);
                end
                if (bus.o_k_i !== 1'b1) begin
                    errors++;
                    $display("FAIL %s k_i run cyc %0d: got %b want 1", name, i, bus.o_k_i);
                end
            end
            if (in_kload || i == 0) begin
                checks++;
                if (bus.o_k_i !== 1'b0) begin
                    errors++;
                    $display("FAIL %s k_i cyc %0d: got %b want 0", name, i, bus.o_k_i);
                end
            end
            if (bus.o_wr_en === 1'b1) writes++;
            if (bus.o_done === 1'b1 && first_done < 0) first_done = i;
            if (issue_idx[i] >= 0) issued++;
            @(posedge clk); #1;
        end
        checks += 2;
        if (writes != len) begin
            errors++;
            $display("FAIL %s write_count: got %0d want %0d", name, writes, len);
        end
        if (first_done != done_c) begin
            errors++;
            $display("FAIL %s done_latency: got %0d want %0d", name, first_done, done_c);
        end
        $display("frame %s len=%0d writes=%0d done_at=%0d", name, len, writes, first_done);
        bus.i_start = 1'b0;
        bus.i_hold  = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({bus.o_conv_rst, bus.o_k_i, bus.o_valid, bus.o_kcol, bus.o_rd_addr,
             bus.o_wr_addr, bus.o_wr_en, bus.o_busy, bus.o_done} !== '0) begin
            errors++;
            $display("FAIL %s outputs: rst=%b k_i=%b valid=%b kcol=%0d rd=%0d wr=%0d wen=%b busy=%b done=%b want all 0",
                     name, bus.o_conv_rst, bus.o_k_i, bus.o_valid, bus.o_kcol, bus.o_rd_addr,
                     bus.o_wr_addr, bus.o_wr_en, bus.o_busy, bus.o_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_start = 1'b0; bus.i_hold = 1'b0; bus.i_img_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        $display("reset released");
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        prep(38);
        run_frame(38, "basic38");
    endtask

    task automatic test_hold();
        prep(38);
        for (int k = 0; k < 3; k++) hold_s[2 + KL + 10 + k] = 1'b1;
        run_frame(38, "hold38");
    endtask

    task automatic test_zero_len();
        prep(0);
        for (int k = 0; k < 2 + KL + 4; k++) start_s[k] = 1'b1;
        run_frame(0, "zero_len");
    endtask

    task automatic test_start_ignored();
        prep(25);
        start_s[2 + KL + 5] = 1'b1;
        len_alt = 7;
        run_frame(25, "start_ignored");
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int len;
            len = $urandom_range(1, 60);
            prep(len);
            len_alt = $urandom_range(0, 100);
            for (int k = 1; k < MAXC; k++) hold_s[k] = ($urandom_range(0, 3) == 0);
            run_frame(len, "random");
        end
    endtask

    task automatic test_back_to_back();
        prep(5);
        run_frame(5, "b2b_a");
        prep(1);
        run_frame(1, "b2b_b");
    endtask

    task automatic test_reset_mid_run();
        int at;
        at = 2 + KL + 7;
        for (int i = 0; i <= at; i++) begin
            bus.i_start   = (i == 0);
            bus.i_hold    = 1'b0;
            bus.i_img_len = NA'(20);
            if (i == at) rst = 1'b1;
            @(negedge clk);
            if (i == at) begin
                checks++;
                if (bus.o_rd_addr !== NA'(7)) begin
                    errors++;
                    $display("FAIL reset_mid rd_addr before reset: got %0d want 7", bus.o_rd_addr);
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        bus.i_start = 1'b0;
        @(negedge clk);
        check_all_zero("reset_mid");
        for (int i = 0; i < WL + 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (bus.o_wr_en !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid idle cyc %0d: wen=%b busy=%b done=%b want 0", i,
                         bus.o_wr_en, bus.o_busy, bus.o_done);
            end
        end
        $display("frame reset_mid aborted at rd_addr=7");
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_zero_len();
        test_start_ignored();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        test_basic();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
